// File: rtl/i2c_slv_ctrl_byte_if.sv
// Bus bundle between the I2C target byte engine and its surroundings: debouncer strobes,
// line drives, and the user-side receive/transmit byte handshake.
interface i2c_slv_ctrl_byte_if #(
   parameter int unsigned HOLD_W = 32
);
   logic              ena;
   logic [6:0]        slv_addr;
   logic [HOLD_W-1:0] thddat;
   logic              sta_det;
   logic              sto_det;
   logic              scl_rising;
   logic              scl_falling;
   logic              sda_i;
   logic              sda_o;
   logic              scl_o;
   logic              addr_match;
   logic              rw;
   logic [7:0]        rx_data;
   logic              rx_vld;
   logic              rx_full;
   logic              tx_req;
   logic              tx_vld;
   logic [7:0]        tx_data;
   logic              busy;

   // Byte engine side
   modport slave (
      input  ena, slv_addr, thddat, sta_det, sto_det, scl_rising, scl_falling, sda_i,
             rx_full, tx_vld, tx_data,
      output sda_o, scl_o, addr_match, rw, rx_data, rx_vld, tx_req, busy
   );

   // Debouncer / user side
   modport master (
      output ena, slv_addr, thddat, sta_det, sto_det, scl_rising, scl_falling, sda_i,
             rx_full, tx_vld, tx_data,
      input  sda_o, scl_o, addr_match, rw, rx_data, rx_vld, tx_req, busy
   );
endinterface

// File: rtl/i2c_slv_ctrl_byte.sv
// I2C target byte engine: decodes the address phase, ACKs on a match, hands received
// bytes to the user and serialises user bytes on reads, stretching SCL until one is ready.
// Every SDA change is delayed by thddat clocks from the SCL falling strobe that opens its bit.
module i2c_slv_ctrl_byte #(
   parameter int unsigned HOLD_W = 32
) (
   input  logic                  clk,
   input  logic                  rstn,
   i2c_slv_ctrl_byte_if.slave    bus
);

   typedef enum logic [3:0] {
      StIdle, StAddr, StAddrAck, StRx, StRxAck, StTxLoad, StTx, StTxAck, StWaitSto
   } state_e;

   localparam logic [HOLD_W-1:0] HoldOne = HOLD_W'(1);

   state_e            state_q, state_d;
   logic [3:0]        bit_cnt_q, bit_cnt_d;
   logic [6:0]        sr_q, sr_d;
   logic [7:0]        tx_sr_q, tx_sr_d;
   logic [7:0]        rx_data_q, rx_data_d;
   logic              rw_q, rw_d;
   logic              nack_q, nack_d;
   logic              ph_q, ph_d;          // second SCL falling of an ACK bit expected
   logic              loaded_q, loaded_d;  // TX byte taken from the user
   logic              drv_q, drv_d;        // TX bit7 already on SDA
   logic              sda_o_q, sda_o_d;
   logic              sda_nxt_q, sda_nxt_d;
   logic              hold_busy_q, hold_busy_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic              addr_match_q, addr_match_d;
   logic              rx_vld_q, rx_vld_d;
   logic              sched, sched_val;
   logic [7:0]        byte_in;

   assign byte_in = {sr_q, bus.sda_i};

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bit_cnt_q    <= '0;
         sr_q         <= '0;
         tx_sr_q      <= '0;
         rx_data_q    <= '0;
         rw_q         <= 1'b0;
         nack_q       <= 1'b0;
         ph_q         <= 1'b0;
         loaded_q     <= 1'b0;
         drv_q        <= 1'b0;
         sda_o_q      <= 1'b1;
         sda_nxt_q    <= 1'b1;
         hold_busy_q  <= 1'b0;
         hold_cnt_q   <= '0;
         addr_match_q <= 1'b0;
         rx_vld_q     <= 1'b0;
      end else begin
         bit_cnt_q    <= bit_cnt_d;
         sr_q         <= sr_d;
         tx_sr_q      <= tx_sr_d;
         rx_data_q    <= rx_data_d;
         rw_q         <= rw_d;
         nack_q       <= nack_d;
         ph_q         <= ph_d;
         loaded_q     <= loaded_d;
         drv_q        <= drv_d;
         sda_o_q      <= sda_o_d;
         sda_nxt_q    <= sda_nxt_d;
         hold_busy_q  <= hold_busy_d;
         hold_cnt_q   <= hold_cnt_d;
         addr_match_q <= addr_match_d;
         rx_vld_q     <= rx_vld_d;
      end
   end

   // Next state, byte handling and hold-delayed SDA scheduling
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      sr_d         = sr_q;
      tx_sr_d      = tx_sr_q;
      rx_data_d    = rx_data_q;
      rw_d         = rw_q;
      nack_d       = nack_q;
      ph_d         = ph_q;
      loaded_d     = loaded_q;
      drv_d        = drv_q;
      sda_o_d      = sda_o_q;
      sda_nxt_d    = sda_nxt_q;
      hold_busy_d  = hold_busy_q;
      hold_cnt_d   = hold_cnt_q;
      addr_match_d = 1'b0;
      rx_vld_d     = 1'b0;
      sched        = 1'b0;
      sched_val    = 1'b1;

      // A pending SDA change lands when its countdown reaches zero
      if (hold_busy_q) begin
         if (hold_cnt_q == '0) begin
            hold_busy_d = 1'b0;
            sda_o_d     = sda_nxt_q;
         end else begin
            hold_cnt_d = hold_cnt_q - HoldOne;
         end
      end

      if (!bus.ena || bus.sto_det || bus.sta_det) begin
         state_d     = bus.ena && !bus.sto_det ? StAddr : StIdle;
         bit_cnt_d   = '0;
         ph_d        = 1'b0;
         loaded_d    = 1'b0;
         drv_d       = 1'b0;
         sda_o_d     = 1'b1;
         hold_busy_d = 1'b0;
      end else begin
         unique case (state_q)
            StIdle, StWaitSto: ;
            StAddr: if (bus.scl_rising) begin
               sr_d      = byte_in[6:0];
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd7) begin
                  bit_cnt_d = '0;
                  ph_d      = 1'b0;
                  if (byte_in[7:1] == bus.slv_addr) begin
                     rw_d         = byte_in[0];
                     addr_match_d = 1'b1;
                     state_d      = StAddrAck;
                  end else begin
                     state_d = StWaitSto;
                  end
               end
            end
            StAddrAck: if (bus.scl_falling) begin
               sched = 1'b1;
               if (!ph_q) begin
                  sched_val = 1'b0;
                  ph_d      = 1'b1;
               end else begin
                  ph_d = 1'b0;
                  if (rw_q) begin
                     // ACK stays on SDA until bit7 replaces it; counter times the hold
                     sched_val = sda_nxt_q;
                     loaded_d  = 1'b0;
                     drv_d     = 1'b0;
                     state_d   = StTxLoad;
                  end else begin
                     state_d = StRx;
                  end
               end
            end
            StRx: if (bus.scl_rising) begin
               sr_d      = byte_in[6:0];
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd7) begin
                  bit_cnt_d = '0;
                  rx_data_d = byte_in;
                  rx_vld_d  = 1'b1;
                  nack_d    = bus.rx_full;
                  ph_d      = 1'b0;
                  state_d   = StRxAck;
               end
            end
            StRxAck: if (bus.scl_falling) begin
               sched = 1'b1;
               if (!ph_q) begin
                  sched_val = nack_q;
                  ph_d      = 1'b1;
               end else begin
                  ph_d    = 1'b0;
                  state_d = nack_q ? StWaitSto : StRx;
               end
            end
            StTxLoad: begin
               if (bus.tx_vld && !loaded_q) begin
                  tx_sr_d  = bus.tx_data;
                  loaded_d = 1'b1;
               end
               if (drv_q) begin
                  bit_cnt_d = '0;
                  state_d   = StTx;
               end else if (loaded_q && (!hold_busy_q || hold_cnt_q == '0)) begin
                  sda_o_d     = tx_sr_q[7];
                  hold_busy_d = 1'b0;
                  drv_d       = 1'b1;
               end
            end
            StTx: if (bus.scl_falling) begin
               sched = 1'b1;
               if (bit_cnt_q == 4'd7) begin
                  bit_cnt_d = '0;
                  ph_d      = 1'b0;
                  state_d   = StTxAck;
               end else begin
                  sched_val = tx_sr_q[6];
                  tx_sr_d   = {tx_sr_q[6:0], 1'b0};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
            StTxAck: begin
               if (bus.scl_rising) begin
                  nack_d = bus.sda_i;
                  ph_d   = 1'b1;
               end else if (bus.scl_falling && ph_q) begin
                  ph_d = 1'b0;
                  if (nack_q) begin
                     state_d = StWaitSto;
                  end else begin
                     sched     = 1'b1;
                     sched_val = sda_nxt_q;
                     loaded_d  = 1'b0;
                     drv_d     = 1'b0;
                     state_d   = StTxLoad;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end

      // thddat=0 applies the change at once, otherwise count down thddat-1 more clocks
      if (sched) begin
         sda_nxt_d = sched_val;
         if (bus.thddat == '0) begin
            sda_o_d     = sched_val;
            hold_busy_d = 1'b0;
         end else begin
            hold_busy_d = 1'b1;
            hold_cnt_d  = bus.thddat - HoldOne;
         end
      end
   end

   // Outputs; disable releases the lines without waiting for a clock
   always_comb begin
      bus.scl_o      = !(bus.ena && state_q == StTxLoad);
      bus.tx_req     = bus.ena && state_q == StTxLoad && !loaded_q;
      bus.sda_o      = sda_o_q | ~bus.ena;
      bus.busy       = state_q != StIdle;
      bus.addr_match = addr_match_q;
      bus.rw         = rw_q;
      bus.rx_data    = rx_data_q;
      bus.rx_vld     = rx_vld_q;
   end

endmodule

// File: tb/tb_i2c_slv_ctrl_byte.sv
// Bench for the I2C target byte engine: a master model issues debouncer strobes, expected
// events (address match, received bytes, 9-bit bus frames) are queued and a monitor compares.
module tb_i2c_slv_ctrl_byte;

   typedef struct packed {
      logic [1:0] kind;
      logic [8:0] val;
   } exp_t;

   localparam logic [1:0] KAm = 2'd0;
   localparam logic [1:0] KRx = 2'd1;
   localparam logic [1:0] KFr = 2'd2;

   logic clk;
   logic rstn;
   logic sda_m;
   int   ntot, nbad, half, cyc, fall_cyc, hold_edges;
   logic hold_chk_en;
   exp_t exp_q[$];

   i2c_slv_ctrl_byte_if #(.HOLD_W(32)) bus ();

   i2c_slv_ctrl_byte #(.HOLD_W(32)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   // Wired-AND SDA line as seen through the debouncer
   assign bus.sda_i = sda_m & bus.sda_o;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ntot++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic sb_check(input logic [1:0] kind, input logic [8:0] val);
      exp_t e;
      ntot++;
      if (exp_q.size() == 0) begin
         nbad++;
         $display("FAIL sb_unexpected: got kind %0d val %0h want nothing", kind, val);
      end else begin
         e = exp_q.pop_front();
         if (e.kind !== kind || e.val !== val) begin
            nbad++;
            $display("FAIL sb_event: got kind %0d val %0h want kind %0d val %0h",
                     kind, val, e.kind, e.val);
         end
      end
   endtask

   task automatic push_am(input logic rw);
      exp_q.push_back('{kind: KAm, val: {8'h00, rw}});
   endtask
   task automatic push_rx(input logic [7:0] d);
      exp_q.push_back('{kind: KRx, val: {1'b0, d}});
   endtask
   task automatic push_fr(input logic [7:0] b, input logic ack);
      exp_q.push_back('{kind: KFr, val: {b, ack}});
   endtask

   // Monitor: DUT pulses, 9-bit frames on the resolved line, SDA hold timing
   initial begin
      int bitn;
      logic [8:0] fr;
      logic sda_prev;
      bitn = 0;
      fr = '0;
      sda_prev = 1'b1;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            bitn = 0;
         end else begin
            if (bus.addr_match) sb_check(KAm, {8'h00, bus.rw});
            if (bus.rx_vld) sb_check(KRx, {1'b0, bus.rx_data});
            if (bus.sta_det || bus.sto_det) bitn = 0;
            if (bus.scl_rising) begin
               fr = {fr[7:0], bus.sda_i};
               bitn++;
               if (bitn == 9) begin
                  sb_check(KFr, fr);
                  bitn = 0;
               end
            end
            if (hold_chk_en && bus.sda_o !== sda_prev) begin
               hold_edges++;
               chk("sda_hold_delay", cyc - fall_cyc, bus.thddat + 1);
            end
            if (bus.scl_falling) fall_cyc = cyc;
         end
         sda_prev = bus.sda_o;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_fall();
      bus.scl_falling = 1'b1;
      tick(1);
      bus.scl_falling = 1'b0;
   endtask

   task automatic pulse_rise();
      int n;
      n = 0;
      while (bus.scl_o !== 1'b1 && n < 500) begin
         tick(1);
         n++;
      end
      chk("scl_released", bus.scl_o, 1'b1);
      bus.scl_rising = 1'b1;
      tick(1);
      bus.scl_rising = 1'b0;
   endtask

   task automatic send_bit(input logic b);
      tick(half);
      sda_m = b;
      tick(2);
      pulse_rise();
      tick(half);
      pulse_fall();
   endtask

   task automatic start(input logic rep);
      if (rep) begin
         tick(half);
         sda_m = 1'b1;
         tick(2);
         pulse_rise();
      end
      tick(half);
      sda_m = 1'b0;
      bus.sta_det = 1'b1;
      tick(1);
      bus.sta_det = 1'b0;
      tick(half);
      pulse_fall();
   endtask

   task automatic stop();
      tick(half);
      sda_m = 1'b0;
      tick(2);
      pulse_rise();
      tick(half);
      sda_m = 1'b1;
      bus.sto_det = 1'b1;
      tick(1);
      bus.sto_det = 1'b0;
      tick(half);
   endtask

   // Master writes a byte and leaves SDA released for the target's ACK
   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      send_bit(1'b1);
   endtask

   // Master reads a byte (target drives) then gives ACK (0) or NACK (1)
   task automatic recv_byte(input logic ack);
      for (int i = 0; i < 8; i++) send_bit(1'b1);
      send_bit(ack);
   endtask

   task automatic give_tx(input logic [7:0] d);
      bus.tx_data = d;
      bus.tx_vld  = 1'b1;
      tick(1);
      bus.tx_vld  = 1'b0;
   endtask

   initial begin
      int n;
      ntot = 0;
      nbad = 0;
      half = 4;
      hold_edges = 0;
      fall_cyc = 0;
      hold_chk_en = 1'b0;
      sda_m = 1'b1;
      rstn = 1'b0;
      bus.ena = 1'b1;
      bus.slv_addr = 7'h50;
      bus.thddat = 32'd0;
      bus.sta_det = 1'b0;
      bus.sto_det = 1'b0;
      bus.scl_rising = 1'b0;
      bus.scl_falling = 1'b0;
      bus.rx_full = 1'b0;
      bus.tx_vld = 1'b0;
      bus.tx_data = 8'h00;
      tick(3);
      rstn = 1'b1;
      tick(2);

      // Reset state
      chk("rst_sda_o", bus.sda_o, 1'b1);
      chk("rst_scl_o", bus.scl_o, 1'b1);
      chk("rst_addr_match", bus.addr_match, 1'b0);
      chk("rst_rw", bus.rw, 1'b0);
      chk("rst_rx_data", bus.rx_data, 8'h00);
      chk("rst_rx_vld", bus.rx_vld, 1'b0);
      chk("rst_tx_req", bus.tx_req, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);

      // Write 0x50/W, 0xA5, 0x3C
      push_am(1'b0);
      push_fr(8'hA0, 1'b0);
      push_rx(8'hA5);
      push_fr(8'hA5, 1'b0);
      push_rx(8'h3C);
      push_fr(8'h3C, 1'b0);
      start(1'b0);
      chk("wr_busy_after_start", bus.busy, 1'b1);
      send_byte(8'hA0);
      send_byte(8'hA5);
      send_byte(8'h3C);
      stop();
      chk("wr_idle_after_stop", bus.busy, 1'b0);

      // Foreign address 0x51: no ACK, parked until STOP
      push_fr(8'hA2, 1'b1);
      start(1'b0);
      send_byte(8'hA2);
      chk("nomatch_wait_sto", bus.busy, 1'b1);
      chk("nomatch_sda_released", bus.sda_o, 1'b1);
      stop();
      chk("nomatch_idle", bus.busy, 1'b0);

      // Read 0x50/R, user answers 20 clocks late with 0xC3, master NACKs
      push_am(1'b1);
      push_fr(8'hA1, 1'b0);
      push_fr(8'hC3, 1'b1);
      start(1'b0);
      send_byte(8'hA1);
      chk("rd_tx_req", bus.tx_req, 1'b1);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.scl_o === 1'b0) n++;
         tick(1);
      end
      chk("rd_scl_stretch_20", n, 20);
      give_tx(8'hC3);
      chk("rd_tx_req_cleared", bus.tx_req, 1'b0);
      give_tx(8'h00);
      recv_byte(1'b1);
      chk("rd_nack_wait_sto", bus.busy, 1'b1);
      chk("rd_nack_tx_req", bus.tx_req, 1'b0);
      chk("rd_nack_sda_released", bus.sda_o, 1'b1);
      stop();

      // rx_full on the second byte: first ACKed, second NACKed
      push_am(1'b0);
      push_fr(8'hA0, 1'b0);
      push_rx(8'h11);
      push_fr(8'h11, 1'b0);
      push_rx(8'h22);
      push_fr(8'h22, 1'b1);
      start(1'b0);
      send_byte(8'hA0);
      send_byte(8'h11);
      bus.rx_full = 1'b1;
      send_byte(8'h22);
      bus.rx_full = 1'b0;
      chk("full_wait_sto", bus.busy, 1'b1);
      stop();

      // Repeated START after 4 data bits, then 0x50/R
      push_am(1'b0);
      push_fr(8'hA0, 1'b0);
      push_am(1'b1);
      push_fr(8'hA1, 1'b0);
      push_fr(8'h5A, 1'b1);
      start(1'b0);
      send_byte(8'hA0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      start(1'b1);
      chk("rs_tx_req_low", bus.tx_req, 1'b0);
      send_byte(8'hA1);
      chk("rs_tx_req_high", bus.tx_req, 1'b1);
      give_tx(8'h5A);
      recv_byte(1'b1);
      stop();

      // thddat=10: every SDA edge 11 clocks after its SCL falling strobe
      bus.thddat = 32'd10;
      half = 14;
      push_am(1'b0);
      push_fr(8'hA0, 1'b0);
      push_rx(8'h96);
      push_fr(8'h96, 1'b0);
      hold_chk_en = 1'b1;
      start(1'b0);
      send_byte(8'hA0);
      send_byte(8'h96);
      stop();
      hold_chk_en = 1'b0;
      chk("hold_edge_count", hold_edges, 4);
      bus.thddat = 32'd0;
      half = 4;

      // Reset while waiting in TX_LOAD
      push_am(1'b1);
      push_fr(8'hA1, 1'b0);
      start(1'b0);
      send_byte(8'hA1);
      tick(5);
      chk("txload_sda_ack_held", bus.sda_o, 1'b0);
      chk("txload_scl_low", bus.scl_o, 1'b0);
      rstn = 1'b0;
      #1;
      chk("rst_mid_sda_o", bus.sda_o, 1'b1);
      chk("rst_mid_scl_o", bus.scl_o, 1'b1);
      chk("rst_mid_tx_req", bus.tx_req, 1'b0);
      chk("rst_mid_busy", bus.busy, 1'b0);
      tick(2);
      sda_m = 1'b1;
      rstn = 1'b1;
      tick(10);

      chk("sb_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", ntot, nbad);
      $finish;
   end

endmodule
